// File: rtl/mfp_uart_pkg.sv
// -----------------------------------------------------------------------------
// mfp_uart_pkg
// Shared definitions for the serial-load receive path:
//   - rx_state_t          : receiver FSM state encoding
//   - calc_clks_per_bit() : rounded clock-cycles-per-bit for a clock/baud pair
// -----------------------------------------------------------------------------
package mfp_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Rounds to the nearest whole cycle so the sample point drifts as little
    // as possible over a 10-bit frame.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// -----------------------------------------------------------------------------
// mfp_sync_fifo
// Single-clock FIFO with a show-ahead read port (rd_data is the current head).
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   push, wr_data     : write request and data; accepted when not full, or
//                       when full and a pop happens in the same cycle
//   pop               : removes the head; ignored while empty
//   rd_data           : head entry, forced to 0 while empty
//   full, empty       : occupancy flags
//   count             : current occupancy (0..DEPTH)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mfp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_FULL);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted; the write lands in the slot being vacated.
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are meaningful, and unreset RAM maps onto
    // plain memory cells instead of a bank of resettable flops.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/mfp_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// mfp_uart_rx_fifo
// 8N1 UART receiver feeding a byte FIFO for the SREC parser.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   rx             : raw asynchronous serial line (idle high)
//   byte_data      : FIFO head byte (0 while empty)
//   byte_valid     : FIFO not empty
//   byte_accept    : consumer pops the head when byte_valid & byte_accept
//   frame_error    : one-cycle pulse when a stop bit samples low
//   overflow       : sticky; a good byte was dropped because the FIFO was full
//   clear_errors   : clears overflow (a same-cycle new overflow wins)
//   fill_level     : FIFO occupancy
// -----------------------------------------------------------------------------
module mfp_uart_rx_fifo
    import mfp_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_accept,
    output logic                          frame_error,
    output logic                          overflow,
    input  logic                          clear_errors,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    // ---------------------------------------------------------------------
    // Two-flop synchroniser; both flops reset to the idle line level so a
    // reset never looks like a start bit.
    // ---------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------------
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             push;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        push        = 1'b0;
        frame_error = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end

            // Re-check the start bit at its centre; a high line here was a
            // glitch, not a character.
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // From the start-bit centre, each full bit period lands on the
            // centre of the next data bit (LSB first).
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        frame_error = 1'b1;
                        state_n     = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Line held low after a bad stop bit: wait for it to return high
            // so the same low level is not taken as a fresh start bit.
            ST_BREAK: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Byte FIFO and overflow flag
    // ---------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic overflow_set;

    mfp_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (shift),
        .pop     (byte_accept),
        .rd_data (byte_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill_level)
    );

    assign byte_valid = ~fifo_empty;

    // Full implies non-empty, so byte_accept alone tells whether a pop frees
    // a slot in the push cycle.
    assign overflow_set = push & fifo_full & ~byte_accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (clear_errors) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mfp_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_mfp_uart_rx_fifo
// Directed bench for the UART receive FIFO. A faster baud ratio than the
// default is used (50 clocks per bit) to keep runs short; the bench derives
// its own bit timing from the same clock/baud pair.
// -----------------------------------------------------------------------------
module tb_mfp_uart_rx_fifo;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int unsigned DEPTH  = 16;
    localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;   // 50
    localparam int HALF = CPB / 2;                      // 25

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     rx;
    logic [7:0]               byte_data;
    logic                     byte_valid;
    logic                     byte_accept;
    logic                     frame_error;
    logic                     overflow;
    logic                     clear_errors;
    logic [$clog2(DEPTH):0]   fill_level;

    int         total = 0;
    int         bad   = 0;
    int         fe_count = 0;
    int         fe_base;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    mfp_uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_accept  (byte_accept),
        .frame_error  (frame_error),
        .overflow     (overflow),
        .clear_errors (clear_errors),
        .fill_level   (fill_level)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_error === 1'b1) fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame starting at the current negedge. With chk_rise the
    // FIFO is expected empty beforehand and byte_valid must rise exactly one
    // cycle after the stop sample. With accept_at_stop, byte_accept is high
    // for precisely the stop-sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit chk_rise, input bit accept_at_stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                if (b == 9 && c == HALF + 1) begin
                    if (chk_rise) check("valid_before_push", 32'(byte_valid), 32'd0);
                    if (accept_at_stop) byte_accept = 1'b1;
                end
                if (b == 9 && c == HALF + 2) begin
                    if (chk_rise) check("valid_after_push", 32'(byte_valid), 32'd1);
                    if (accept_at_stop) byte_accept = 1'b0;
                end
            end
        end
        if (stop) begin
            if (accept_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic drain();
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            check("fill_before_pop", 32'(fill_level), 32'(exp_q.size()));
            check("valid_before_pop", 32'(byte_valid), 32'd1);
            e = exp_q.pop_front();
            check("byte_data", 32'(byte_data), 32'(e));
            byte_accept = 1'b1;
            @(negedge clock);
            byte_accept = 1'b0;
        end
        check("drained_fill", 32'(fill_level), 32'd0);
        check("drained_valid", 32'(byte_valid), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        byte_accept  = 1'b0;
        clear_errors = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_data", 32'(byte_data), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: single 'S'
        send_frame(8'h53, 1'b1, 1'b1, 1'b0);
        check("t1_fill", 32'(fill_level), 32'd1);
        drain();
        check("t1_fe", 32'(fe_count), 32'd0);

        // Accept while empty has no effect
        byte_accept = 1'b1;
        repeat (3) @(negedge clock);
        byte_accept = 1'b0;
        check("empty_accept_fill", 32'(fill_level), 32'd0);
        check("empty_accept_valid", 32'(byte_valid), 32'd0);

        // 2: short low glitch shorter than half a bit
        rx = 1'b0;
        repeat (HALF / 2) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("t2_fe", 32'(fe_count), 32'd0);
        check("t2_fill", 32'(fill_level), 32'd0);
        check("t2_valid", 32'(byte_valid), 32'd0);

        // 3: bad stop bit, line held low, then a good byte
        fe_base = fe_count;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (4 * CPB) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("t3_fe_pulses", 32'(fe_count - fe_base), 32'd1);
        check("t3_fill", 32'(fill_level), 32'd0);
        send_frame(8'h30, 1'b1, 1'b1, 1'b0);
        drain();
        check("t3_fe_after", 32'(fe_count - fe_base), 32'd1);

        // 4: overflow with consumer stalled
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 15) begin
                check("t4_fill_full", 32'(fill_level), 32'd16);
                check("t4_ovf_before", 32'(overflow), 32'd0);
            end
        end
        check("t4_fill", 32'(fill_level), 32'd16);
        check("t4_ovf", 32'(overflow), 32'(exp_ovf));
        drain();
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        exp_ovf = 1'b0;
        check("t4_ovf_clear", 32'(overflow), 32'(exp_ovf));

        // 5: push into a full FIFO with a pop in the stop-sample cycle
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
        end
        check("t5_fill_pre", 32'(fill_level), 32'd16);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        check("t5_fill", 32'(fill_level), 32'd16);
        check("t5_ovf", 32'(overflow), 32'd0);
        drain();

        // 6: reset in the middle of data bit 4, then a good byte
        fe_base = fe_count;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int b = 0; b < 4; b++) begin
            rx = b[0];
            repeat (CPB) @(negedge clock);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);
        check("t6_fill", 32'(fill_level), 32'd0);
        check("t6_valid", 32'(byte_valid), 32'd0);
        check("t6_fe", 32'(fe_count - fe_base), 32'd0);
        send_frame(8'h3A, 1'b1, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
